// File: rtl/rollover_monitor.sv
// Rollover interval monitor: measures cycles between transitions of an upstream
// counter MSB, flags early/late transitions and counts correct intervals.
module rollover_monitor #(
  parameter int unsigned HALF_PERIOD = 32768,
  parameter int unsigned CW          = 16
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_rollover,
  input  logic          i_clear,
  output logic          o_edge,
  output logic          o_locked,
  output logic          o_err_early,
  output logic          o_err_late,
  output logic [CW-1:0] o_interval,
  output logic [7:0]    o_periods
);

  typedef enum logic [1:0] {IDLE, TRACK, ERROR} state_t;

  localparam logic [CW-1:0] HP  = CW'(HALF_PERIOD);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] SAT = '1;

  state_t        state, state_nx;
  logic [1:0]    rst_sync;
  logic          rst_int_n;
  logic          r_last, r_primed;
  logic [CW-1:0] r_since, since_nx;
  logic          transition;
  logic          primed_nx, edge_nx, locked_nx, early_nx, late_nx;
  logic [CW-1:0] interval_nx;
  logic [7:0]    periods_nx;

  // Reset asserts asynchronously but releases only on a clock edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign transition = r_primed && (i_rollover != r_last);

  always_ff @(posedge i_clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state       <= IDLE;
      r_last      <= 1'b0;
      r_primed    <= 1'b0;
      r_since     <= '0;
      o_edge      <= 1'b0;
      o_locked    <= 1'b0;
      o_err_early <= 1'b0;
      o_err_late  <= 1'b0;
      o_interval  <= '0;
      o_periods   <= '0;
    end else begin
      state       <= state_nx;
      r_last      <= i_rollover;
      r_primed    <= primed_nx;
      r_since     <= since_nx;
      o_edge      <= edge_nx;
      o_locked    <= locked_nx;
      o_err_early <= early_nx;
      o_err_late  <= late_nx;
      o_interval  <= interval_nx;
      o_periods   <= periods_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    primed_nx   = 1'b1;
    since_nx    = r_since;
    edge_nx     = 1'b0;
    locked_nx   = o_locked;
    early_nx    = o_err_early;
    late_nx     = o_err_late;
    interval_nx = o_interval;
    periods_nx  = o_periods;
    if (i_clear) begin
      // Clear wins over a coincident transition, so no edge pulse either.
      state_nx   = IDLE;
      primed_nx  = 1'b0;
      since_nx   = '0;
      locked_nx  = 1'b0;
      early_nx   = 1'b0;
      late_nx    = 1'b0;
      periods_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (transition) begin
            state_nx = TRACK;
            since_nx = ONE;
            edge_nx  = 1'b1;
          end
        end
        TRACK: begin
          if (transition) begin
            edge_nx  = 1'b1;
            since_nx = ONE;
            if (r_since == HP) begin
              interval_nx = HP;
              locked_nx   = 1'b1;
              if (o_periods != 8'hFF) periods_nx = o_periods + 8'd1;
            end else begin
              state_nx    = ERROR;
              early_nx    = 1'b1;
              interval_nx = r_since;
              locked_nx   = 1'b0;
            end
          end else if (r_since == HP) begin
            state_nx  = ERROR;
            late_nx   = 1'b1;
            locked_nx = 1'b0;
          end else if (r_since != SAT) begin
            since_nx = r_since + ONE;
          end
        end
        ERROR: begin
          if (transition) edge_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: doc/rollover_monitor.md
ROLLOVER_MONITOR -- requirements
Module: rollover_monitor

Interface
REQ-001 Parameter HALF_PERIOD, default 32768: required cycle count between successive i_rollover transitions.
REQ-002 Parameter CW, default 16: interval counter and o_interval width; SHALL satisfy 2^CW > HALF_PERIOD.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 i_rollover  input  1  rollover (counter MSB) level from the upstream free-running counter, same clock domain.
REQ-006 i_clear  input  1  synchronous clear of error, lock and statistics.
REQ-007 o_edge  output  1  one-cycle pulse per accepted i_rollover transition.
REQ-008 o_locked  output  1  at least one correct interval measured, no error since.
REQ-009 o_err_early  output  1  sticky: transition arrived before HALF_PERIOD cycles.
REQ-010 o_err_late  output  1  sticky: no transition by HALF_PERIOD cycles.
REQ-011 o_interval  output  CW  last measured interval, in cycles.
REQ-012 o_periods  output  8  saturating count of correct intervals.

Function
REQ-013 All outputs SHALL be registered; no combinational input-to-output path.
REQ-014 r_last SHALL sample i_rollover every cycle; transition = i_rollover != r_last, valid only when r_primed = 1.
REQ-015 r_primed SHALL be 0 after reset or i_clear and set 1 after the first sampled cycle; transitions while r_primed = 0 are ignored.
REQ-016 States: IDLE, TRACK, ERROR; reset state IDLE.
REQ-017 IDLE: on valid transition -> TRACK, r_since <= 1, o_edge = 1 next cycle; o_interval unchanged.
REQ-018 TRACK: r_since increments each cycle without transition, saturating at 2^CW-1.
REQ-019 TRACK, transition with r_since == HALF_PERIOD: stay TRACK; o_interval <= HALF_PERIOD; o_periods += 1 (saturate at 255); o_locked <= 1; r_since <= 1; o_edge pulses.
REQ-020 TRACK, transition with r_since < HALF_PERIOD: -> ERROR; o_err_early <= 1; o_interval <= r_since; o_locked <= 0; o_edge pulses.
REQ-021 TRACK, no transition with r_since == HALF_PERIOD: -> ERROR next cycle; o_err_late <= 1; o_locked <= 0; o_interval unchanged.
REQ-022 ERROR: sticky; transitions still pulse o_edge but update no other output; o_periods frozen.
REQ-023 i_clear SHALL take priority over every transition in any state: -> IDLE; o_locked, both error flags, o_periods, r_since, r_primed <= 0; o_interval kept.
REQ-024 Latency: o_edge, o_interval, o_periods, flags update exactly one cycle after the transition cycle.
REQ-025 o_err_early and o_err_late SHALL never both be 1.

Reset
REQ-026 Assertion of i_reset_n = 0 SHALL immediately force: state IDLE, r_last 0, r_primed 0, r_since 0, o_edge 0, o_locked 0, o_err_early 0, o_err_late 0, o_interval 0, o_periods 0.
REQ-027 Reset deassertion SHALL be synchronized to i_clk; first sampled cycle after release only primes r_last (REQ-015).
REQ-028 Reset mid-TRACK or mid-ERROR SHALL discard all measurement state with no spurious o_edge.

Verification (HALF_PERIOD = 8, CW = 4)
REQ-029 Toggle i_rollover every 8 cycles for 5 toggles -> o_edge 5 pulses, o_periods = 4, o_locked = 1, o_interval = 8, no errors.
REQ-030 Lock, then toggle after 5 cycles -> o_err_early = 1, o_interval = 5, o_locked = 0, state ERROR.
REQ-031 Lock, then hold i_rollover -> o_err_late = 1 on cycle 9 after last edge, o_interval stays 8.
REQ-032 Hold i_rollover = 1 across reset release -> no o_edge, state IDLE until a real transition.
REQ-033 In ERROR, pulse i_clear same cycle as a transition -> IDLE, flags 0, o_periods 0, no lock; next two 8-cycle toggles relock with o_periods = 1.
REQ-034 Drive 300 correct intervals -> o_periods saturates at 255; async reset mid-interval zeroes all outputs within that cycle.
